// File: rtl/impl_window_checker.sv
// impl_window_checker
// Multi-channel run-time checker for the timed implication
//   a |-> ##[MIN_DLY:MAX_DLY] b
// Each channel tracks one outstanding attempt and reports pass/fail/drop
// pulses, a busy flag, a sticky error flag and saturating pass/fail counters.
// All outputs are registered; rst and clr clear everything synchronously.

module impl_window_checker #(
    parameter int CHANNELS = 4,
    parameter int MIN_DLY  = 1,
    parameter int MAX_DLY  = 1,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr,
    input  logic [CHANNELS-1:0]       a,
    input  logic [CHANNELS-1:0]       b,
    output logic [CHANNELS-1:0]       pass,
    output logic [CHANNELS-1:0]       fail,
    output logic [CHANNELS-1:0]       drop,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       err,
    output logic [CHANNELS*CNT_W-1:0] pass_cnt,
    output logic [CHANNELS*CNT_W-1:0] fail_cnt
);

    // Delay counter wide enough to hold MAX_DLY, never narrower than 1 bit.
    localparam int DLY_W = (MAX_DLY < 1) ? 1 : $clog2(MAX_DLY + 1);
    localparam logic [DLY_W-1:0] MIN_D = DLY_W'(MIN_DLY);
    localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DLY);
    localparam logic [DLY_W-1:0] ONE_D = DLY_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch

        state_t             r_state;
        state_t             w_state_nxt;
        logic [DLY_W-1:0]   r_dly;
        logic [DLY_W-1:0]   w_dly_nxt;
        logic               r_pass;
        logic               r_fail;
        logic               r_drop;
        logic               r_err;
        logic [CNT_W-1:0]   r_pcnt;
        logic [CNT_W-1:0]   r_fcnt;
        logic               w_start;
        logic               w_ge_min;
        logic               w_pass;
        logic               w_fail;
        logic               w_drop;

        assign w_start = en & a[gi];

        // With MIN_DLY of zero every delay is inside the window; the
        // explicit split avoids a constant-true unsigned comparison.
        if (MIN_DLY == 0) begin : g_min_zero
            assign w_ge_min = 1'b1;
        end else begin : g_min_nonzero
            assign w_ge_min = (r_dly >= MIN_D);
        end

        // Next-state, delay counter and per-attempt event decode.
        always_comb begin
            w_state_nxt = r_state;
            w_dly_nxt   = r_dly;
            w_pass      = 1'b0;
            w_fail      = 1'b0;
            w_drop      = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if ((MIN_DLY == 0) && b[gi]) begin
                            w_pass = 1'b1;
                        end else if (MAX_DLY == 0) begin
                            w_fail = 1'b1;
                        end else begin
                            w_state_nxt = S_WAIT;
                            w_dly_nxt   = ONE_D;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_ge_min && b[gi]) begin
                        w_pass = 1'b1;
                    end else if (r_dly == MAX_D) begin
                        w_fail = 1'b1;
                    end
                    // A resolving cycle may immediately re-arm; the b that
                    // resolved the old attempt is never seen by the new one.
                    if (w_pass || w_fail) begin
                        if (w_start) begin
                            w_state_nxt = S_WAIT;
                            w_dly_nxt   = ONE_D;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_dly_nxt   = '0;
                        end
                    end else begin
                        w_dly_nxt = r_dly + ONE_D;
                        w_drop    = w_start;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_dly_nxt   = '0;
                end
            endcase
        end

        // State register, registered pulses, sticky error and saturating counters.
        always_ff @(posedge clk) begin
            if (rst || clr) begin
                r_state <= S_IDLE;
                r_dly   <= '0;
                r_pass  <= 1'b0;
                r_fail  <= 1'b0;
                r_drop  <= 1'b0;
                r_err   <= 1'b0;
                r_pcnt  <= '0;
                r_fcnt  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_dly   <= w_dly_nxt;
                r_pass  <= w_pass;
                r_fail  <= w_fail;
                r_drop  <= w_drop;
                r_err   <= r_err | w_fail;
                if (w_pass && (r_pcnt != '1)) begin
                    r_pcnt <= r_pcnt + CNT_W'(1);
                end
                if (w_fail && (r_fcnt != '1)) begin
                    r_fcnt <= r_fcnt + CNT_W'(1);
                end
            end
        end

        assign pass[gi]                     = r_pass;
        assign fail[gi]                     = r_fail;
        assign drop[gi]                     = r_drop;
        assign busy[gi]                     = (r_state == S_WAIT);
        assign err[gi]                      = r_err;
        assign pass_cnt[gi*CNT_W +: CNT_W]  = r_pcnt;
        assign fail_cnt[gi*CNT_W +: CNT_W]  = r_fcnt;
    end

endmodule

// File: tb/tb_impl_window_checker.sv
// Self-checking bench for impl_window_checker using four differently
// parameterised instances: non-overlapped (1..1), window (2..4),
// overlapped with narrow counters (0..0, CNT_W=2) and a 1..3 window for
// channel independence and reset mid-attempt.

module tb_impl_window_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // U1: CHANNELS=4, MIN=1, MAX=1, CNT_W=16
    logic        en1, clr1;
    logic [3:0]  a1, b1, p1, f1, d1, bz1, e1;
    logic [63:0] pc1, fc1;
    // U2: CHANNELS=1, MIN=2, MAX=4, CNT_W=8
    logic        en2, clr2, a2, b2, p2, f2, d2, bz2, e2;
    logic [7:0]  pc2, fc2;
    // U3: CHANNELS=1, MIN=0, MAX=0, CNT_W=2
    logic        en3, clr3, a3, b3, p3, f3, d3, bz3, e3;
    logic [1:0]  pc3, fc3;
    // U4: CHANNELS=4, MIN=1, MAX=3, CNT_W=8
    logic        en4, clr4;
    logic [3:0]  a4, b4, p4, f4, d4, bz4, e4;
    logic [31:0] pc4, fc4;

    impl_window_checker #(.CHANNELS(4), .MIN_DLY(1), .MAX_DLY(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .en(en1), .clr(clr1), .a(a1), .b(b1),
        .pass(p1), .fail(f1), .drop(d1), .busy(bz1), .err(e1),
        .pass_cnt(pc1), .fail_cnt(fc1));

    impl_window_checker #(.CHANNELS(1), .MIN_DLY(2), .MAX_DLY(4), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .en(en2), .clr(clr2), .a(a2), .b(b2),
        .pass(p2), .fail(f2), .drop(d2), .busy(bz2), .err(e2),
        .pass_cnt(pc2), .fail_cnt(fc2));

    impl_window_checker #(.CHANNELS(1), .MIN_DLY(0), .MAX_DLY(0), .CNT_W(2)) u3 (
        .clk(clk), .rst(rst), .en(en3), .clr(clr3), .a(a3), .b(b3),
        .pass(p3), .fail(f3), .drop(d3), .busy(bz3), .err(e3),
        .pass_cnt(pc3), .fail_cnt(fc3));

    impl_window_checker #(.CHANNELS(4), .MIN_DLY(1), .MAX_DLY(3), .CNT_W(8)) u4 (
        .clk(clk), .rst(rst), .en(en4), .clr(clr4), .a(a4), .b(b4),
        .pass(p4), .fail(f4), .drop(d4), .busy(bz4), .err(e4),
        .pass_cnt(pc4), .fail_cnt(fc4));

    typedef struct {
        logic [3:0]  a, b;
        logic        en, clr;
        logic [3:0]  p, f, d, bz, e;
        logic [15:0] pc, fc;     // channel 0 counters
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int va, vb, ven, vclr, vp, vf, vd, vbz, ve, vpc, vfc);
        vec_t v;
        v.a   = 4'(va);
        v.b   = 4'(vb);
        v.en  = 1'(ven);
        v.clr = 1'(vclr);
        v.p   = 4'(vp);
        v.f   = 4'(vf);
        v.d   = 4'(vd);
        v.bz  = 4'(vbz);
        v.e   = 4'(ve);
        v.pc  = 16'(vpc);
        v.fc  = 16'(vfc);
        return v;
    endfunction

    // Drive one vector into u1 (sel=1) or u2 (sel=2), clock it, compare.
    task automatic run_vec(input int sel, input vec_t v, input string tag, input int idx);
        logic [19:0] flags;
        logic [15:0] gpc, gfc;
        if (sel == 1) begin
            a1 = v.a; b1 = v.b; en1 = v.en; clr1 = v.clr;
        end else begin
            a2 = v.a[0]; b2 = v.b[0]; en2 = v.en; clr2 = v.clr;
        end
        @(posedge clk);
        #1;
        if (sel == 1) begin
            flags = {p1, f1, d1, bz1, e1};
            gpc   = pc1[15:0];
            gfc   = fc1[15:0];
        end else begin
            flags = {3'b0, p2, 3'b0, f2, 3'b0, d2, 3'b0, bz2, 3'b0, e2};
            gpc   = {8'b0, pc2};
            gfc   = {8'b0, fc2};
        end
        chk($sformatf("%s[%0d].flags", tag, idx), 64'(flags), 64'({v.p, v.f, v.d, v.bz, v.e}));
        chk($sformatf("%s[%0d].cnt", tag, idx), 64'({gpc, gfc}), 64'({v.pc, v.fc}));
    endtask

    task automatic step3(input logic ta, input logic tb, input logic tclr);
        a3 = ta; b3 = tb; clr3 = tclr;
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic [3:0] ta, input logic [3:0] tb);
        a4 = ta; b4 = tb;
        @(posedge clk);
        #1;
    endtask

    vec_t t1[$];
    vec_t t2[$];

    initial begin
        rst = 1'b1;
        en1 = 1'b0; clr1 = 1'b0; a1 = '0; b1 = '0;
        en2 = 1'b0; clr2 = 1'b0; a2 = 1'b0; b2 = 1'b0;
        en3 = 1'b0; clr3 = 1'b0; a3 = 1'b0; b3 = 1'b0;
        en4 = 1'b0; clr4 = 1'b0; a4 = '0; b4 = '0;

        //        a  b  en clr  p  f  d  bz e   pc fc
        t1.push_back(mk(0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0));
        t1.push_back(mk(1, 1, 1, 0,  0, 0, 0, 1, 0,  0, 0));
        t1.push_back(mk(1, 1, 1, 0,  1, 0, 0, 1, 0,  1, 0));
        t1.push_back(mk(0, 1, 1, 0,  1, 0, 0, 0, 0,  2, 0));
        t1.push_back(mk(2, 0, 1, 0,  0, 0, 0, 2, 0,  2, 0));
        t1.push_back(mk(1, 2, 1, 0,  2, 0, 0, 1, 0,  2, 0));
        t1.push_back(mk(0, 0, 1, 0,  0, 1, 0, 0, 1,  2, 1));
        t1.push_back(mk(0, 1, 1, 0,  0, 0, 0, 0, 1,  2, 1));
        t1.push_back(mk(1, 1, 1, 0,  0, 0, 0, 1, 1,  2, 1));
        t1.push_back(mk(0, 1, 1, 0,  1, 0, 0, 0, 1,  3, 1));
        t1.push_back(mk(1, 0, 1, 0,  0, 0, 0, 1, 1,  3, 1));
        t1.push_back(mk(1, 0, 1, 0,  0, 1, 0, 1, 1,  3, 2));
        t1.push_back(mk(0, 1, 1, 0,  1, 0, 0, 0, 1,  4, 2));
        t1.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 1,  4, 2));
        t1.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 1,  4, 2));
        t1.push_back(mk(1, 0, 1, 0,  0, 0, 0, 1, 1,  4, 2));
        t1.push_back(mk(1, 1, 0, 0,  1, 0, 0, 0, 1,  5, 2));
        t1.push_back(mk(1, 0, 1, 0,  0, 0, 0, 1, 1,  5, 2));
        t1.push_back(mk(1, 1, 1, 1,  0, 0, 0, 0, 0,  0, 0));
        t1.push_back(mk(0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0));

        t2.push_back(mk(1, 0, 1, 0,  0, 0, 0, 1, 0,  0, 0));
        t2.push_back(mk(0, 1, 1, 0,  0, 0, 0, 1, 0,  0, 0));
        t2.push_back(mk(1, 0, 1, 0,  0, 0, 1, 1, 0,  0, 0));
        t2.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 0,  0, 0));
        t2.push_back(mk(0, 0, 1, 0,  0, 1, 0, 0, 1,  0, 1));
        t2.push_back(mk(0, 0, 1, 0,  0, 0, 0, 0, 1,  0, 1));
        t2.push_back(mk(1, 0, 1, 0,  0, 0, 0, 1, 1,  0, 1));
        t2.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 1,  0, 1));
        t2.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 1,  0, 1));
        t2.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 1,  0, 1));
        t2.push_back(mk(0, 1, 1, 0,  1, 0, 0, 0, 1,  1, 1));
        t2.push_back(mk(1, 0, 1, 0,  0, 0, 0, 1, 1,  1, 1));
        t2.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 1,  1, 1));
        t2.push_back(mk(1, 1, 1, 0,  1, 0, 0, 1, 1,  2, 1));
        t2.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 1,  2, 1));
        t2.push_back(mk(0, 1, 1, 0,  1, 0, 0, 0, 1,  3, 1));
        t2.push_back(mk(0, 0, 1, 0,  0, 0, 0, 0, 1,  3, 1));

        // Reset state of every instance.
        repeat (2) @(posedge clk);
        #1;
        chk("reset.u1.flags", 64'({p1, f1, d1, bz1, e1}), 64'd0);
        chk("reset.u1.pc", pc1, 64'd0);
        chk("reset.u1.fc", fc1, 64'd0);
        chk("reset.u2", 64'({p2, f2, d2, bz2, e2, pc2, fc2}), 64'd0);
        chk("reset.u3", 64'({p3, f3, d3, bz3, e3, pc3, fc3}), 64'd0);
        chk("reset.u4.flags", 64'({p4, f4, d4, bz4, e4}), 64'd0);
        chk("reset.u4.cnt", {pc4, fc4}, 64'd0);
        rst = 1'b0;

        // Non-overlapped: back-to-back, fail/re-arm, en gating, clr.
        for (int i = 0; i < t1.size(); i++) run_vec(1, t1[i], "u1", i);
        a1 = '0; b1 = '0;

        // Window 2..4: early b ignored, drop, fail at MAX, pass at MAX/MIN, re-arm.
        for (int i = 0; i < t2.size(); i++) run_vec(2, t2[i], "u2", i);
        a2 = 1'b0; b2 = 1'b0;

        // Overlapped with 2-bit counters: pass, fail, saturation, clr over a pass.
        en3 = 1'b1;
        step3(1'b1, 1'b1, 1'b0);
        chk("u3.pass0.flags", 64'({p3, f3, d3, bz3, e3}), 64'b10000);
        chk("u3.pass0.cnt", 64'({pc3, fc3}), 64'({2'd1, 2'd0}));
        step3(1'b1, 1'b0, 1'b0);
        chk("u3.fail.flags", 64'({p3, f3, d3, bz3, e3}), 64'b01001);
        chk("u3.fail.cnt", 64'({pc3, fc3}), 64'({2'd1, 2'd1}));
        for (int i = 0; i < 4; i++) begin
            int exp_pc;
            exp_pc = (i + 2 > 3) ? 3 : i + 2;
            step3(1'b1, 1'b1, 1'b0);
            chk($sformatf("u3.sat%0d.flags", i), 64'({p3, f3, d3, bz3, e3}), 64'b10001);
            chk($sformatf("u3.sat%0d.pc", i), 64'(pc3), 64'(exp_pc));
        end
        step3(1'b1, 1'b1, 1'b1);
        chk("u3.clr.flags", 64'({p3, f3, d3, bz3, e3}), 64'd0);
        chk("u3.clr.cnt", 64'({pc3, fc3}), 64'd0);
        step3(1'b0, 1'b0, 1'b0);
        chk("u3.idle", 64'({p3, f3, d3, bz3, e3, pc3, fc3}), 64'd0);

        // Independent channels on a 1..3 window; ch3 never sees b and fails.
        en4 = 1'b1;
        step4(4'b1111, 4'b0000);
        chk("u4.start.flags", 64'({p4, f4, d4, bz4, e4}), 64'({4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000}));
        step4(4'b0000, 4'b0001);
        chk("u4.d1.flags", 64'({p4, f4, d4, bz4, e4}), 64'({4'b0001, 4'b0000, 4'b0000, 4'b1110, 4'b0000}));
        step4(4'b0000, 4'b0010);
        chk("u4.d2.flags", 64'({p4, f4, d4, bz4, e4}), 64'({4'b0010, 4'b0000, 4'b0000, 4'b1100, 4'b0000}));
        step4(4'b0000, 4'b0100);
        chk("u4.d3.flags", 64'({p4, f4, d4, bz4, e4}), 64'({4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b1000}));
        chk("u4.d3.pc", 64'(pc4), 64'h0001_0101);
        chk("u4.d3.fc", 64'(fc4), 64'h0100_0000);

        // Reset while ch0 is pending: everything clears and no fail follows.
        step4(4'b0001, 4'b0000);
        chk("u4.pend.flags", 64'({p4, f4, d4, bz4, e4}), 64'({4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1000}));
        rst = 1'b1;
        step4(4'b0000, 4'b0000);
        rst = 1'b0;
        chk("u4.rst.flags", 64'({p4, f4, d4, bz4, e4}), 64'd0);
        chk("u4.rst.cnt", {pc4, fc4}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step4(4'b0000, 4'b0000);
            chk($sformatf("u4.post_rst%0d", i), 64'({p4, f4, d4, bz4, e4}), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
